// File: rtl/mux_share_sched_pkg.sv
// Shared types and pin map for the four-source time-division output scheduler.
package mux_share_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int unsigned NREQ          = 4;
    localparam int unsigned DATA_LSB      = 0;
    localparam int unsigned REQ_LSB       = 4;
    localparam int unsigned CFG_MODE      = 4;
    localparam int unsigned CFG_LOCK      = 5;
    localparam int unsigned OUT_GRANT_LSB = 1;
    localparam int unsigned OUT_SEL_LSB   = 5;
    localparam int unsigned OUT_BUSY      = 7;
    localparam int unsigned SLOT_W_MAX    = 8;

    // A zero slot length stands for the full 2**w cycles.
    function automatic logic [SLOT_W_MAX:0] slot_load(input logic [SLOT_W_MAX-1:0] len,
                                                      input int unsigned w);
        if (len == '0) begin
            slot_load = {{SLOT_W_MAX{1'b0}}, 1'b1} << w;
        end else begin
            slot_load = {1'b0, len};
        end
    endfunction

endpackage

// File: rtl/mux_share_pick.sv
// Combinational request picker: round-robin after the last owner, or fixed lowest-index priority.
module mux_share_pick
    import mux_share_sched_pkg::*;
(
    input  logic [NREQ-1:0] req_s_i,
    input  logic [1:0]      last_i,
    input  logic            mode_i,
    output logic            valid_o,
    output logic [1:0]      idx_o
);

    logic [1:0] cand;
    logic       found;

    always_comb begin
        valid_o = |req_s_i;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            // Round-robin scans from one past the previous owner, wrapping mod 4.
            cand = mode_i ? 2'(k) : last_i + 2'(k + 1);
            if (!found && req_s_i[cand]) begin
                idx_o = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_share_sched.sv
// Time-division scheduler sharing uo_out[0] among four sources with slot, gap and lock control.
module mux_share_sched
    import mux_share_sched_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SLOT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned CNT_W = SLOT_W + 1;

    logic [NREQ-1:0]  sync_q [SYNC_STAGES];
    logic [NREQ-1:0]  req_s;
    logic [NREQ-1:0]  data_bits;
    logic             mode;
    logic             lock;
    logic [CNT_W-1:0] slot_ld;
    logic             unused_cfg;

    state_e           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] slot_q, slot_d;
    logic             data_q, data_d;
    logic             busy_q, busy_d;

    logic             pick_valid;
    logic [1:0]       pick_idx;
    logic             grant_end;

    assign data_bits  = ui_in[DATA_LSB +: NREQ];
    assign mode       = uio_in[CFG_MODE];
    assign lock       = uio_in[CFG_LOCK];
    assign slot_ld    = CNT_W'(slot_load(SLOT_W_MAX'(uio_in[SLOT_W-1:0]), SLOT_W));
    assign unused_cfg = ^uio_in[7:6];
    assign req_s      = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= ui_in[REQ_LSB +: NREQ];
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    mux_share_pick u_pick (
        .req_s_i (req_s),
        .last_i  (last_q),
        .mode_i  (mode),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Lock only holds the slot open while the owner keeps requesting.
    assign grant_end = !req_s[sel_q] ||
                       ((slot_q == CNT_W'(1)) && !(lock && req_s[sel_q]));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        slot_d  = slot_q;
        data_d  = data_q;
        case (state_q)
            IDLE, GAP: begin
                grant_d = '0;
                data_d  = 1'b0;
                if (pick_valid) begin
                    state_d = GRANT;
                    grant_d = NREQ'(1) << pick_idx;
                    sel_d   = pick_idx;
                    slot_d  = slot_ld;
                end else begin
                    state_d = IDLE;
                    sel_d   = '0;
                end
            end
            GRANT: begin
                data_d = data_bits[sel_q];
                slot_d = (slot_q > CNT_W'(1)) ? slot_q - CNT_W'(1) : slot_q;
                if (grant_end) begin
                    state_d = GAP;
                    grant_d = '0;
                    data_d  = 1'b0;
                    last_d  = sel_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                sel_d   = '0;
                data_d  = 1'b0;
            end
        endcase
        if (!ena) begin
            state_d = IDLE;
            grant_d = '0;
            sel_d   = '0;
            data_d  = 1'b0;
            last_d  = last_q;
            slot_d  = slot_q;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= 2'(NREQ - 1);
            slot_q  <= '0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            slot_q  <= slot_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        uo_out                          = '0;
        uo_out[0]                       = data_q;
        uo_out[OUT_GRANT_LSB +: NREQ]   = grant_q;
        uo_out[OUT_SEL_LSB +: 2]        = sel_q;
        uo_out[OUT_BUSY]                = busy_q;
    end

    assign uio_out = '0;
    assign uio_oe  = '0;

endmodule

// File: tb/tb_mux_share_sched.sv
// Scoreboarded bench: directed scenarios queue expected grant episodes, a negedge monitor checks them.
module tb_mux_share_sched;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    mux_share_sched #(.SYNC_STAGES(2), .SLOT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] sel;
        logic [7:0] len;
    } ep_t;

    ep_t         exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [3:0]  cur_g   = '0;
    logic [1:0]  cur_sel = '0;
    logic [7:0]  cur_len = '0;
    logic [15:0] pat     = 16'h002C;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic expect_ep(input logic [3:0] g, input logic [1:0] s, input logic [7:0] l);
        exp_q.push_back('{g: g, sel: s, len: l});
    endtask

    task automatic close_ep();
        ep_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL episode: unexpected grant %b sel %0d len %0d", cur_g, cur_sel, cur_len);
        end else begin
            e = exp_q.pop_front();
            if (e.g !== cur_g || e.sel !== cur_sel || e.len !== cur_len) begin
                n_bad++;
                $display("FAIL episode: got grant %b sel %0d len %0d expected grant %b sel %0d len %0d",
                         cur_g, cur_sel, cur_len, e.g, e.sel, e.len);
            end
        end
        cur_len = '0;
    endtask

    // Grant episodes: contiguous cycles of non-zero grant, closed when grant drops or changes.
    always @(negedge clk) begin
        if (uo_out[4:1] != 4'b0000) begin
            if (cur_len != 0 && uo_out[4:1] != cur_g) close_ep();
            if (cur_len == 0) begin
                cur_g   = uo_out[4:1];
                cur_sel = uo_out[6:5];
            end
            cur_len++;
        end else if (cur_len != 0) begin
            close_ep();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = '0;
        uio_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_uo_out", uo_out, 8'h00);
        rst_n = 1'b1;
    endtask

    initial begin
        // Single requester, slot 3, data lag
        do_reset();
        chk("reset_uio_out", uio_out, 8'h00);
        chk("reset_uio_oe", uio_oe, 8'h00);
        uio_in = 8'h03;
        ui_in  = 8'h10;
        expect_ep(4'b0001, 2'd0, 8'd3);
        expect_ep(4'b0001, 2'd0, 8'd3);
        for (int n = 1; n <= 14; n++) begin
            ui_in[0] = pat[n-1];
            if (n == 9) ui_in[4] = 1'b0;
            tick();
            if (n == 2) chk("t1_latency_pre", uo_out, 8'h00);
            if (n == 3) chk("t1_first_grant", uo_out, 8'h82);
            if (n == 4 || n == 5) chk("t1_data_lag", {7'b0, uo_out[0]}, {7'b0, pat[n-1]});
            if (n == 6) chk("t1_gap", uo_out, 8'h80);
            if (n == 13) chk("t1_idle", uo_out, 8'h00);
        end
        chk("t1_queue_empty", 8'(exp_q.size()), 8'd0);

        // Four requesters, round-robin, slot 2
        do_reset();
        uio_in = 8'h02;
        ui_in  = 8'hF0;
        expect_ep(4'b0001, 2'd0, 8'd2);
        expect_ep(4'b0010, 2'd1, 8'd2);
        expect_ep(4'b0100, 2'd2, 8'd2);
        expect_ep(4'b1000, 2'd3, 8'd2);
        expect_ep(4'b0001, 2'd0, 8'd2);
        for (int n = 1; n <= 20; n++) begin
            if (n == 16) ui_in[7:4] = 4'b0000;
            tick();
            if (n == 5) chk("t2_gap", uo_out, 8'h80);
            if (n == 6) chk("t2_second", uo_out, 8'hA4);
        end
        chk("t2_queue_empty", 8'(exp_q.size()), 8'd0);

        // Fixed priority, slot 1: source 3 starves
        do_reset();
        uio_in = 8'h11;
        ui_in  = 8'hA0;
        repeat (5) expect_ep(4'b0010, 2'd1, 8'd1);
        for (int n = 1; n <= 14; n++) begin
            if (n == 10) ui_in[7:4] = 4'b0000;
            tick();
            if (n == 4) chk("t3_gap", uo_out, 8'hA0);
        end
        chk("t3_queue_empty", 8'(exp_q.size()), 8'd0);

        // Early release mid-slot, then next requester
        do_reset();
        uio_in = 8'h08;
        ui_in  = 8'h30;
        expect_ep(4'b0001, 2'd0, 8'd5);
        expect_ep(4'b0010, 2'd1, 8'd8);
        for (int n = 1; n <= 20; n++) begin
            if (n == 6) ui_in[4] = 1'b0;
            if (n == 16) ui_in[5] = 1'b0;
            tick();
            if (n == 7) chk("t4_held", uo_out, 8'h82);
            if (n == 8) chk("t4_release_gap", uo_out, 8'h80);
            if (n == 9) chk("t4_next", uo_out, 8'hA4);
        end
        chk("t4_queue_empty", 8'(exp_q.size()), 8'd0);

        // Lock holds past the slot length
        do_reset();
        uio_in = 8'h22;
        ui_in  = 8'h10;
        expect_ep(4'b0001, 2'd0, 8'd10);
        for (int n = 1; n <= 16; n++) begin
            if (n == 11) ui_in[4] = 1'b0;
            tick();
            if (n == 12) chk("t5_locked", uo_out, 8'h82);
            if (n == 13) chk("t5_gap", uo_out, 8'h80);
            if (n == 15) chk("t5_idle", uo_out, 8'h00);
        end
        chk("t5_queue_empty", 8'(exp_q.size()), 8'd0);

        // Slot length 0 encodes 16
        do_reset();
        uio_in = 8'h00;
        ui_in  = 8'h10;
        expect_ep(4'b0001, 2'd0, 8'd16);
        for (int n = 1; n <= 22; n++) begin
            if (n == 18) ui_in[4] = 1'b0;
            tick();
            if (n == 18) chk("t6_last_cycle", uo_out, 8'h82);
            if (n == 19) chk("t6_gap", uo_out, 8'h80);
        end
        chk("t6_queue_empty", 8'(exp_q.size()), 8'd0);

        // Asynchronous reset mid-grant
        do_reset();
        uio_in = 8'h08;
        ui_in  = 8'h10;
        expect_ep(4'b0001, 2'd0, 8'd2);
        for (int n = 1; n <= 5; n++) tick();
        chk("t7_pre_reset", uo_out, 8'h82);
        rst_n = 1'b0;
        #1;
        chk("t7_async_reset", uo_out, 8'h00);
        ui_in = 8'h00;
        tick();
        tick();
        chk("t7_queue_empty", 8'(exp_q.size()), 8'd0);

        // ena low mid-grant, resume from unchanged RR pointer
        do_reset();
        uio_in = 8'h04;
        ui_in  = 8'h30;
        expect_ep(4'b0001, 2'd0, 8'd2);
        expect_ep(4'b0001, 2'd0, 8'd4);
        expect_ep(4'b0010, 2'd1, 8'd4);
        for (int n = 1; n <= 20; n++) begin
            if (n == 5) ena = 1'b0;
            if (n == 8) ena = 1'b1;
            if (n == 16) ui_in[7:4] = 4'b0000;
            tick();
            if (n == 5) chk("t8_ena_low", uo_out, 8'h00);
            if (n == 7) chk("t8_ena_hold", uo_out, 8'h00);
            if (n == 8) chk("t8_resume", uo_out, 8'h82);
            if (n == 13) chk("t8_rr_next", uo_out, 8'hA4);
        end
        chk("t8_queue_empty", 8'(exp_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mux_share_sched.md
Name: mux_share_sched

Overview:
- Time-division scheduler that shares the single-bit selectable output channel (uo_out[0]) among four requesting data sources.
- Arbitrates synchronized requests using round-robin or fixed priority, then grants a programmable slot.
- Drives the mux select and registers the selected bit onto the output pin.
- Top-level tile block; all pins map onto the standard tile interface.

Parameters:
- SYNC_STAGES, 2: flop stages on each req input (min 1).
- SLOT_W, 4: slot counter width; slot length config is SLOT_W bits.

Ports:
- clk  in  1  clock (single clock domain).
- rst_n  in  1  reset; asynchronous, active-low.
- ena  in  1  design enable; low = synchronous hold in IDLE.
- ui_in  in  8  [3:0] data bit of source 0..3; [7:4] req[3:0].
- uio_in  in  8  [3:0] slot_len; [4] mode (0 round-robin, 1 fixed priority, lowest index wins); [5] lock; [7:6] unused.
- uo_out  out  8  [0] data_q; [4:1] grant one-hot; [6:5] sel index; [7] busy.
- uio_out  out  8  tied 0.
- uio_oe  out  8  tied 0 (all uio pins are inputs).

Behaviour:
- Reset (async, immediate): state=IDLE, sync flops=0, grant=0, sel=0, data_q=0, busy=0, slot_cnt=0, last=3 (first RR winner is lowest requester).
- req[3:0] passes through SYNC_STAGES flops to give req_s. Data bits and uio config are not synchronized; they are treated as quasi-static.
- States: IDLE, GRANT, GAP.
- IDLE:
  - Outputs 0.
  - If any req_s, the winner is the first set bit scanning (last+1) mod 4 upward (mode 0) or the lowest set index (mode 1).
  - Next edge: GRANT, grant=onehot(winner), sel=winner, slot_cnt=slot_len (0 encodes 16).
  - Latency: grant is high SYNC_STAGES+1 edges after the req pin rises.
- GRANT:
  - data_q <= ui_in[sel] each edge; data_q lags the pin by 1 cycle.
  - slot_cnt decrements each cycle.
  - End condition: !req_s[sel] (early release) OR (slot_cnt==1 AND !(lock AND req_s[sel])).
  - While lock holds, slot_cnt saturates at 1.
  - On end, next edge: GAP, grant=0, data_q=0, last=sel.
- GAP:
  - Exactly one cycle; grant=0, data_q=0, busy=1.
  - Arbitrates as in IDLE, using the updated last. Any req_s goes directly to GRANT, else IDLE.
  - The previous owner may win again only if no other requester is active (mode 0), or if it is the lowest index (mode 1).
- busy = (state != IDLE), registered.
- slot_len is sampled only at grant load; mode is sampled only at arbitration; lock is evaluated every GRANT cycle.
- Undisturbed grant with slot_len N lasts exactly N cycles (16 for N=0), followed by 1 GAP cycle.
- ena low: next edge forces IDLE and clears grant, sel, data_q and busy. last and the sync flops keep running.
- Requests appearing mid-slot are never granted before GAP; no preemption.
- Reset asserted mid-GRANT: all outputs 0 immediately, with no GAP cycle.

Decomposition:
- Package mux_share_sched_pkg:
  - state enum (IDLE, GRANT, GAP).
  - pin index constants: DATA_LSB=0, REQ_LSB=4, CFG_MODE=4, CFG_LOCK=5, OUT_GRANT_LSB=1, OUT_SEL_LSB=5, OUT_BUSY=7.
  - NREQ=4.
  - slot_len zero-encodes-16 rule as a function.
- Sub-module mux_share_pick: combinational picker. Inputs req_s[3:0], last[1:0], mode. Outputs valid and idx[1:0]. Unit-testable on its own.

Test Plan:
- Reset, then req=0001, slot_len=3, mode=0 -> grant=0001 at edge 3 after req, held 3 cycles, 1 GAP, re-grant 0001; data_q follows ui_in[0] with 1-cycle lag.
- req=1111, slot_len=2, mode=0 -> grant order 0001,0010,0100,1000,0001, each 2 cycles with 1 GAP between.
- req=1010, mode=1, slot_len=1 -> only 0010 granted repeatedly (1 cycle on, 1 GAP); source 3 starves.
- Owner drops req mid-slot with slot_len=8 -> grant falls SYNC_STAGES+1 edges after the pin falls; GAP follows; next requester granted.
- lock=1, slot_len=2, owner holds req 10 cycles -> grant stays 0001 until req_s falls, then GAP; slot_len=0 without lock -> 16-cycle grant.
- rst_n low mid-GRANT -> uo_out=0 with no clock edge. ena low mid-GRANT -> IDLE, uo_out=0 next edge; ena high again with req pending -> grant resumes from the RR pointer.
